adjexp_pipe: RTL and testbench
==============================

Name: adjexp_pipe

Overview:
- Parametrised, pipelined successor to the rounder's exponent-adjust stage.
- Takes the post-rounding exponent and the significand-overflow flag, increments the exponent and detects exponent overflow for single- or double-format operands.
- Applies either the IEEE trapped wrap (subtract alpha) or the untrapped clamp to the largest finite exponent.
- Sits between the significand rounder and the result packer, behind a 2-stage valid/ready pipeline; keeps a sticky overflow flag.

Parameters:
- EW, 11, double-format exponent width; the datapath width.
- SW, 8, single-format exponent width; must satisfy SW < EW.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- e2  in  EW  rounded exponent; single format uses bits [SW-1:0] only
- db  in  1  1 = double format, 0 = single format
- sigovf  in  1  significand overflowed during rounding; exponent must be incremented
- ovf_en  in  1  overflow trap enabled
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- e3  out  EW  adjusted exponent; single results are zero-extended above bit SW-1
- ovf  out  1  exponent overflow occurred for this beat
- sig_max  out  1  untrapped overflow; packer substitutes the all-ones significand
- clr_sticky  in  1  clears ovf_sticky
- ovf_sticky  out  1  set by any delivered beat with ovf=1

Behaviour:
- Width: w = EW if db, else SW. allones = 2^w-1. emax = 2^w-2. alpha = 3*2^(w-2). All arithmetic is on w+1 bits; the result is truncated to w bits and zero-extended to EW.
- sum = e2[w-1:0] + sigovf.
- ovf = (sum >= allones).
- ovf=1 and ovf_en=1: e3 = (sum - alpha) mod 2^w, sig_max=0.
- ovf=1 and ovf_en=0: e3 = emax, sig_max=1.
- ovf=0: e3 = sum, sig_max=0.
- Stage 1 registers db, ovf_en, sum and ovf.
- Stage 2 registers e3, ovf and sig_max.
- Latency: exactly 2 cycles from input handshake to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Handshake: in_ready = ~s1_valid | (~s2_valid | out_ready). Each stage advances when its successor is empty or advancing.
- in_valid may be held while in_ready=0; inputs are sampled only on in_valid & in_ready.
- Back-pressure with out_ready=0: out_valid, e3, ovf and sig_max hold stable. Both stages fill, then in_ready=0. No beat is dropped or duplicated.
- Sticky flag: ovf_sticky sets on out_valid & out_ready & ovf. clr_sticky clears it. If set and clear occur in the same cycle, set wins.
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - e3=0, ovf=0, sig_max=0, ovf_sticky=0.
  - in_ready=1 after reset deasserts.
  - In-flight beats are discarded on reset mid-operation.
- Upper-bit rule: for single format, e2[EW-1:SW] is ignored. Results do not depend on it.

Optional Feature:
- Macro: ADJEXP_OVF_CNT_EN.
- Defined: adds output ovf_cnt [15:0].
  - Increments on each delivered beat with ovf=1 and saturates at 0xFFFF.
  - clr_sticky also zeroes it; same-cycle clear and increment yields 1.
  - Resets to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package adjexp_pkg holds:
  - constants EW_D=11 and EW_S=8;
  - functions f_emax(w), f_alpha(w), f_allones(w);
  - a packed struct for the stage-1 payload {db, ovf_en, sum, ovf}.
- Sub-module adjexp_core: a purely combinational sum/overflow/select datapath, instantiated once across the stage boundary. adjexp_pipe owns the valid/ready control, the registers, the sticky flag and the counter.

Test Plan:
- Double, no overflow: e2=0x3FF, sigovf=1, ovf_en=0 -> 2 cycles later e3=0x400, ovf=0, sig_max=0.
- Double trapped: e2=0x7FE, sigovf=1, ovf_en=1 -> e3=0x1FF, ovf=1, sig_max=0, ovf_sticky=1 after the handshake.
- Single untrapped: db=0, e2=0x7FF (upper bits ignored, field=0xFF), sigovf=0, ovf_en=0 -> e3=0x0FE, ovf=1, sig_max=1.
- Single trapped: db=0, e2=0x0FF, sigovf=1, ovf_en=1 -> e3=0x040, ovf=1.
- Back-pressure: stream 5 beats with out_ready=0 for 4 cycles. Require:
  - in_ready drops after 2 beats are accepted;
  - all 5 beats emerge in order, unchanged, once out_ready=1.
- Reset and sticky:
  - Assert rst_n=0 with 2 beats in flight -> out_valid=0 and ovf_sticky=0 immediately (asynchronous).
  - clr_sticky coincident with an overflow delivery -> ovf_sticky stays 1.
  - With ADJEXP_OVF_CNT_EN defined, ovf_cnt=1 after that same-cycle clear and delivery.

Source files
------------

// File: rtl/adjexp_pkg.sv
// Shared constants, helper functions and the stage-1 payload type for the
// exponent-adjust pipeline (adjexp_pipe / adjexp_core).
package adjexp_pkg;

  localparam int EW_D = 11;
  localparam int EW_S = 8;

  // Stage-1 payload; the sum field is sized for the double format, so EW must not exceed EW_D.
  typedef struct packed {
    logic          db;
    logic          ovf_en;
    logic [EW_D:0] sum;
    logic          ovf;
  } s1_payload_t;

  function automatic int unsigned f_allones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned f_emax(input int unsigned w);
    return (32'd1 << w) - 32'd2;
  endfunction

  function automatic int unsigned f_alpha(input int unsigned w);
    return 32'd3 << (w - 32'd2);
  endfunction

endpackage

// File: rtl/adjexp_core.sv
// Combinational datapath of the exponent-adjust stage: the increment/overflow half
// feeds stage 1, the wrap/clamp select half consumes the registered stage-1 payload.
module adjexp_core
  import adjexp_pkg::*;
#(
  parameter int EW = EW_D,
  parameter int SW = EW_S
) (
  input  logic [EW-1:0] i_e2,
  input  logic          i_db,
  input  logic          i_sigovf,
  output logic [EW:0]   o_sum,
  output logic          o_ovf,
  input  s1_payload_t   i_s1,
  output logic [EW-1:0] o_e3,
  output logic          o_sig_max
);

  logic [EW:0]   w_mask1;
  logic [EW:0]   w_field;
  logic [EW:0]   w_sum2;
  logic [EW-1:0] w_wrap;
  logic [EW-1:0] w_emax;
  int unsigned   w_w1;
  int unsigned   w_w2;

  // Masking to the active width discards e2[EW-1:SW] for single format.
  always_comb begin
    w_w1    = i_db ? EW : SW;
    w_mask1 = (EW+1)'(f_allones(w_w1));
    w_field = {1'b0, i_e2} & w_mask1;
    o_sum   = w_field + (EW+1)'(i_sigovf);
    o_ovf   = (o_sum >= w_mask1);
  end

  always_comb begin
    w_w2      = i_s1.db ? EW : SW;
    w_sum2    = (EW+1)'(i_s1.sum);
    w_wrap    = EW'(w_sum2 - (EW+1)'(f_alpha(w_w2))) & EW'(f_allones(w_w2));
    w_emax    = EW'(f_emax(w_w2));
    o_e3      = EW'(w_sum2);
    o_sig_max = 1'b0;
    if (i_s1.ovf) begin
      if (i_s1.ovf_en) begin
        o_e3 = w_wrap;
      end else begin
        o_e3      = w_emax;
        o_sig_max = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adjexp_pipe.sv
// Two-stage valid/ready exponent-adjust pipeline with sticky overflow flag.
// Optional saturating overflow counter output ovf_cnt when ADJEXP_OVF_CNT_EN is defined.
module adjexp_pipe
  import adjexp_pkg::*;
#(
  parameter int EW = EW_D,
  parameter int SW = EW_S
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] e2,
  input  logic          db,
  input  logic          sigovf,
  input  logic          ovf_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] e3,
  output logic          ovf,
  output logic          sig_max,
  input  logic          clr_sticky,
  output logic          ovf_sticky
`ifdef ADJEXP_OVF_CNT_EN
  ,
  output logic [15:0]   ovf_cnt
`endif
);

  logic          r_s1_valid;
  s1_payload_t   r_s1;
  logic          r_s2_valid;
  logic [EW-1:0] r_e3;
  logic          r_ovf;
  logic          r_sig_max;
  logic          r_sticky;

  logic [EW:0]   w_sum;
  logic          w_ovf;
  logic [EW-1:0] w_e3;
  logic          w_sig_max;
  logic          w_s2_ready;
  logic          w_in_ready;
  logic          w_deliver_ovf;

  adjexp_core #(.EW(EW), .SW(SW)) u_core (
    .i_e2      (e2),
    .i_db      (db),
    .i_sigovf  (sigovf),
    .o_sum     (w_sum),
    .o_ovf     (w_ovf),
    .i_s1      (r_s1),
    .o_e3      (w_e3),
    .o_sig_max (w_sig_max)
  );

  assign w_s2_ready    = ~r_s2_valid | out_ready;
  assign w_in_ready    = ~r_s1_valid | w_s2_ready;
  assign w_deliver_ovf = r_s2_valid & out_ready & r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1.db     <= db;
        r_s1.ovf_en <= ovf_en;
        r_s1.sum    <= (EW_D+1)'(w_sum);
        r_s1.ovf    <= w_ovf;
      end
    end
  end

  // Stage 2 holds its beat steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_e3       <= '0;
      r_ovf      <= 1'b0;
      r_sig_max  <= 1'b0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_e3      <= w_e3;
        r_ovf     <= r_s1.ovf;
        r_sig_max <= w_sig_max;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (w_deliver_ovf) begin
      r_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_sticky <= 1'b0;
    end
  end

`ifdef ADJEXP_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  // A clear that coincides with a counted delivery leaves exactly that one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= '0;
    end else if (clr_sticky) begin
      r_ovf_cnt <= w_deliver_ovf ? 16'd1 : 16'd0;
    end else if (w_deliver_ovf && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;
  assign e3         = r_e3;
  assign ovf        = r_ovf;
  assign sig_max    = r_sig_max;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_adjexp_pipe.sv
// Self-checking bench for adjexp_pipe: vector table, scoreboard monitor,
// back-pressure, mid-flight reset and sticky-flag corner cases.
module tb_adjexp_pipe;

  logic        clk;
  logic        rst_n;
  logic        inValid;
  logic        inReady;
  logic [10:0] e2;
  logic        db;
  logic        sigovf;
  logic        ovfEn;
  logic        outValid;
  logic        outReady;
  logic [10:0] e3;
  logic        ovf;
  logic        sigMax;
  logic        clrSticky;
  logic        ovfSticky;
`ifdef ADJEXP_OVF_CNT_EN
  logic [15:0] ovfCnt;
`endif

  typedef struct {
    logic        db;
    logic [10:0] e2;
    logic        sigovf;
    logic        ovfEn;
    logic [10:0] e3;
    logic        ovf;
    logic        sigMax;
  } vec_t;

  typedef struct {
    logic [10:0] e3;
    logic        ovf;
    logic        sigMax;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  vec_t vecs[12];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   acceptCount = 0;
  bit   randDone;

  adjexp_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .e2         (e2),
    .db         (db),
    .sigovf     (sigovf),
    .ovf_en     (ovfEn),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .e3         (e3),
    .ovf        (ovf),
    .sig_max    (sigMax),
    .clr_sticky (clrSticky),
    .ovf_sticky (ovfSticky)
`ifdef ADJEXP_OVF_CNT_EN
    ,
    .ovf_cnt    (ovfCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Behavioural reference used for the random beats.
  function automatic exp_t model(input logic d, input logic [10:0] e, input logic so, input logic en);
    exp_t r;
    int w, full, sum;
    w    = d ? 11 : 8;
    full = 1 << w;
    sum  = (int'(e) % full) + int'(so);
    r.sigMax = 1'b0;
    r.ovf    = (sum >= full - 1);
    if (!r.ovf)    r.e3 = 11'(sum);
    else if (en)   r.e3 = 11'((sum - 3 * (full / 4)) % full);
    else begin
      r.e3     = 11'(full - 2);
      r.sigMax = 1'b1;
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic applyStimulus(input logic d, input logic [10:0] e, input logic so, input logic en, input exp_t x);
    int waited = 0;
    db = d; e2 = e; sigovf = so; ovfEn = en; inValid = 1'b1;
    @(negedge clk);
    while (!inReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!inReady) checkOutput("in_ready_timeout", 32'(inReady), 32'd1);
    else begin
      sb.push_back(x);
      acceptCount++;
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic drainQueue();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && outValid && outReady) begin
      if (sb.size() == 0) checkOutput("unexpected_beat", 32'd1, 32'd0);
      else begin
        monExp = sb.pop_front();
        checkOutput("e3", 32'(e3), 32'(monExp.e3));
        checkOutput("ovf", 32'(ovf), 32'(monExp.ovf));
        checkOutput("sig_max", 32'(sigMax), 32'(monExp.sigMax));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] heldE3;
    exp_t x;
    logic rd, rs, re;
    logic [10:0] re2;

    vecs[0]  = '{1'b1, 11'h3FF, 1'b1, 1'b0, 11'h400, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 11'h7FE, 1'b1, 1'b1, 11'h1FF, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 11'h7FF, 1'b0, 1'b0, 11'h0FE, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 11'h0FF, 1'b1, 1'b1, 11'h040, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 11'h7FE, 1'b0, 1'b0, 11'h7FE, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 11'h7FF, 1'b1, 1'b1, 11'h200, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 11'h7FF, 1'b1, 1'b0, 11'h7FE, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 11'h0FD, 1'b1, 1'b1, 11'h0FE, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 11'h3FE, 1'b1, 1'b0, 11'h0FE, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 11'h5FF, 1'b0, 1'b1, 11'h03F, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 11'h000, 1'b0, 1'b1, 11'h000, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 11'h6FE, 1'b0, 1'b1, 11'h0FE, 1'b0, 1'b0};

    rst_n = 1'b0; inValid = 1'b0; e2 = '0; db = 1'b0; sigovf = 1'b0;
    ovfEn = 1'b0; outReady = 1'b1; clrSticky = 1'b0;
    #12;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_e3", 32'(e3), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_sig_max", 32'(sigMax), 32'd0);
    checkOutput("rst_sticky", 32'(ovfSticky), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);

    // Two-cycle latency on the first beat.
    x = '{vecs[0].e3, vecs[0].ovf, vecs[0].sigMax};
    applyStimulus(vecs[0].db, vecs[0].e2, vecs[0].sigovf, vecs[0].ovfEn, x);
    @(negedge clk);
    checkOutput("lat_cycle1_valid", 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput("lat_cycle2_valid", 32'(outValid), 32'd1);
    @(posedge clk);
    #1;
    drainQueue();

    for (int i = 0; i < 12; i++) begin
      x = '{vecs[i].e3, vecs[i].ovf, vecs[i].sigMax};
      applyStimulus(vecs[i].db, vecs[i].e2, vecs[i].sigovf, vecs[i].ovfEn, x);
    end
    drainQueue();
    checkOutput("sticky_set", 32'(ovfSticky), 32'd1);
    clrSticky = 1'b1;
    @(posedge clk);
    #1;
    clrSticky = 1'b0;
    checkOutput("sticky_clear", 32'(ovfSticky), 32'd0);

    // Back-pressure: five beats against a stalled consumer.
    outReady = 1'b0;
    acceptCount = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          x = '{vecs[i+4].e3, vecs[i+4].ovf, vecs[i+4].sigMax};
          applyStimulus(vecs[i+4].db, vecs[i+4].e2, vecs[i+4].sigovf, vecs[i+4].ovfEn, x);
        end
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("bp_in_ready_low", 32'(inReady), 32'd0);
        checkOutput("bp_accepted", 32'(acceptCount), 32'd2);
        heldE3 = e3;
        @(negedge clk);
        checkOutput("bp_valid_held", 32'(outValid), 32'd1);
        checkOutput("bp_e3_held", 32'(e3), 32'(heldE3));
        checkOutput("bp_e3_first", 32'(e3), 32'(vecs[4].e3));
        @(posedge clk);
        #1;
        outReady = 1'b1;
      end
    join
    drainQueue();

    // Random beats with a randomly stalling consumer.
    randDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          rd = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          re = 1'($urandom_range(0, 1));
          re2 = (i % 3 == 0) ? 11'h7FF - 11'($urandom_range(0, 1)) : 11'($urandom_range(0, 2047));
          applyStimulus(rd, re2, rs, re, model(rd, re2, rs, re));
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1;
          outReady = 1'($urandom_range(0, 1));
        end
      end
    join
    outReady = 1'b1;
    drainQueue();

    // Reset with two beats in flight; sticky is set beforehand so its clear is visible.
    x = '{vecs[1].e3, vecs[1].ovf, vecs[1].sigMax};
    applyStimulus(vecs[1].db, vecs[1].e2, vecs[1].sigovf, vecs[1].ovfEn, x);
    drainQueue();
    checkOutput("sticky_before_rst", 32'(ovfSticky), 32'd1);
    applyStimulus(vecs[5].db, vecs[5].e2, vecs[5].sigovf, vecs[5].ovfEn, x);
    applyStimulus(vecs[6].db, vecs[6].e2, vecs[6].sigovf, vecs[6].ovfEn, x);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("midrst_out_valid", 32'(outValid), 32'd0);
    checkOutput("midrst_sticky", 32'(ovfSticky), 32'd0);
    checkOutput("midrst_e3", 32'(e3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_in_ready", 32'(inReady), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_ghost", 32'(outValid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Clear coincident with an overflow delivery: set wins.
    x = '{vecs[3].e3, vecs[3].ovf, vecs[3].sigMax};
    applyStimulus(vecs[3].db, vecs[3].e2, vecs[3].sigovf, vecs[3].ovfEn, x);
    @(posedge clk);
    #1;
    clrSticky = 1'b1;
    @(negedge clk);
    checkOutput("sc_delivery_cycle", 32'(outValid), 32'd1);
    @(posedge clk);
    #1;
    clrSticky = 1'b0;
    checkOutput("sc_sticky_wins", 32'(ovfSticky), 32'd1);
`ifdef ADJEXP_OVF_CNT_EN
    checkOutput("sc_cnt_one", 32'(ovfCnt), 32'd1);
`endif
    drainQueue();
    clrSticky = 1'b1;
    @(posedge clk);
    #1;
    clrSticky = 1'b0;
    checkOutput("final_sticky_clear", 32'(ovfSticky), 32'd0);
`ifdef ADJEXP_OVF_CNT_EN
    checkOutput("final_cnt_clear", 32'(ovfCnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
